// File: rtl/controle_cronometro.sv
// Stopwatch master controller: debounces four buttons, runs the ZERADO/CONTANDO/PAUSADO/PARADO FSM,
// emits one-cycle command pulses and the 1 s tick. Define TOGGLE_START_EN for single-button start/stop.
module controle_cronometro #(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int CLK_DIV         = 50000000
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       btn_iniciar,
    input  logic       btn_pausar,
    input  logic       btn_parar,
    input  logic       btn_zerar,
    output logic       cmd_contar,
    output logic       cmd_pausar,
    output logic       cmd_parar,
    output logic       cmd_zerar,
    output logic       tick_seg,
    output logic [1:0] estado
);

    localparam int DBW = $clog2(DEBOUNCE_CYCLES);
    localparam int PW  = $clog2(CLK_DIV);

    // Button vector index doubles as the index of the command it requests.
    localparam int B_INI = 0;
    localparam int B_PAU = 1;
    localparam int B_PAR = 2;
    localparam int B_ZER = 3;

    typedef enum logic [1:0] {
        ZERADO   = 2'd0,
        CONTANDO = 2'd1,
        PAUSADO  = 2'd2,
        PARADO   = 2'd3
    } estado_t;

    logic [3:0]    btn;
    logic [3:0]    sync1_q, sync2_q;
    logic [3:0]    deb_q, deb_d, deb_dly_q;
    logic [3:0]    arm_q, arm_d;
    logic [3:0]    ev_q, ev_d;
    logic [1:0]    vld_q;
    estado_t       state_q, state_d;
    logic [3:0]    cmd_q, cmd_d;
    logic [PW-1:0] presc_q, presc_d;
    logic          counting;

    assign btn = {btn_zerar, btn_parar, btn_pausar, btn_iniciar};

    // A button only produces events once its synchronized level has been seen low
    // after reset, so a button held through reset release stays silent.
    assign arm_d = arm_q | ({4{vld_q[1]}} & ~sync2_q & ~deb_q);
    assign ev_d  = deb_q & ~deb_dly_q & arm_q;

    for (genvar gi = 0; gi < 4; gi++) begin : g_deb
        logic [DBW-1:0] cnt_q, cnt_d;
        logic           flip;

        always_comb begin
            cnt_d = '0;
            flip  = 1'b0;
            if (sync2_q[gi] != deb_q[gi]) begin
                if (cnt_q == DBW'(DEBOUNCE_CYCLES - 1)) flip  = 1'b1;
                else                                    cnt_d = cnt_q + 1'b1;
            end
        end

        always_ff @(posedge clock or negedge reset) begin
            if (!reset) cnt_q <= '0;
            else        cnt_q <= cnt_d;
        end

        assign deb_d[gi] = deb_q[gi] ^ flip;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sync1_q   <= '0;
            sync2_q   <= '0;
            deb_q     <= '0;
            deb_dly_q <= '0;
            arm_q     <= '0;
            ev_q      <= '0;
            vld_q     <= '0;
        end else begin
            sync1_q   <= btn;
            sync2_q   <= sync1_q;
            deb_q     <= deb_d;
            deb_dly_q <= deb_q;
            arm_q     <= arm_d;
            ev_q      <= ev_d;
            vld_q     <= {vld_q[0], 1'b1};
        end
    end

    // Priority zerar > parar > pausar > iniciar; an illegal event falls through to the next one.
    always_comb begin
        state_d = state_q;
        cmd_d   = '0;
        if (ev_q[B_ZER]) begin
            state_d      = ZERADO;
            cmd_d[B_ZER] = 1'b1;
        end else if (ev_q[B_PAR] && (state_q == CONTANDO || state_q == PAUSADO)) begin
            state_d      = PARADO;
            cmd_d[B_PAR] = 1'b1;
        end else if (ev_q[B_PAU] && state_q == CONTANDO) begin
            state_d      = PAUSADO;
            cmd_d[B_PAU] = 1'b1;
        end else if (ev_q[B_INI]) begin
`ifdef TOGGLE_START_EN
            if (state_q == CONTANDO || state_q == PAUSADO) begin
                state_d      = PARADO;
                cmd_d[B_PAR] = 1'b1;
            end else begin
                state_d      = CONTANDO;
                cmd_d[B_INI] = 1'b1;
            end
`else
            if (state_q != CONTANDO) begin
                state_d      = CONTANDO;
                cmd_d[B_INI] = 1'b1;
            end
`endif
        end
    end

    assign counting = (state_q == CONTANDO) || (state_q == PAUSADO);

    // Prescaler freezes in PARADO so a resumed second continues where it stopped.
    always_comb begin
        presc_d = presc_q;
        if (state_d == ZERADO)                         presc_d = '0;
        else if (counting && presc_q == PW'(CLK_DIV - 1)) presc_d = '0;
        else if (counting)                             presc_d = presc_q + 1'b1;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= ZERADO;
            cmd_q   <= '0;
            presc_q <= '0;
        end else begin
            state_q <= state_d;
            cmd_q   <= cmd_d;
            presc_q <= presc_d;
        end
    end

    assign tick_seg   = counting && (presc_q == PW'(CLK_DIV - 1));
    assign estado     = state_q;
    assign cmd_contar = cmd_q[B_INI];
    assign cmd_pausar = cmd_q[B_PAU];
    assign cmd_parar  = cmd_q[B_PAR];
    assign cmd_zerar  = cmd_q[B_ZER];

endmodule

// File: tb/tb_controle_cronometro.sv
// Randomized bench for controle_cronometro against a window-based reference model.
// Build with or without +define+TOGGLE_START_EN; the model follows the same macro.
module tb_controle_cronometro;

    localparam int D = 4;
    localparam int C = 10;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       bi = 1'b0, bpa = 1'b0, bpr = 1'b0, bz = 1'b0;
    logic       cmd_contar, cmd_pausar, cmd_parar, cmd_zerar, tick_seg;
    logic [1:0] estado;

    controle_cronometro #(.DEBOUNCE_CYCLES(D), .CLK_DIV(C)) dut (
        .clock      (clock),
        .reset      (reset),
        .btn_iniciar(bi),
        .btn_pausar (bpa),
        .btn_parar  (bpr),
        .btn_zerar  (bz),
        .cmd_contar (cmd_contar),
        .cmd_pausar (cmd_pausar),
        .cmd_parar  (cmd_parar),
        .cmd_zerar  (cmd_zerar),
        .tick_seg   (tick_seg),
        .estado     (estado)
    );

    always #5 clock = ~clock;

    int n_chk  = 0;
    int n_fail = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0d, expected %0d", tag, $time, got, exp);
        end
    endtask

    // Reference model: edges numbered from 1 after reset release; raw samples kept per button.
    int       e;
    bit       hist[4][$];
    bit       deb[4];
    bit       armed[4];
    int       evdue[4];
    int       mst;
    bit [3:0] mcmd;
    int       mp;

    // Level the debouncer sees at edge k: raw input two edges earlier (0 before that exists).
    function automatic bit samp(input int b, input int k);
        return (k >= 3) ? hist[b][k-3] : 1'b0;
    endfunction

    task automatic model_reset();
        e = 0;
        for (int b = 0; b < 4; b++) begin
            hist[b].delete();
            deb[b]   = 1'b0;
            armed[b] = 1'b0;
            evdue[b] = -1;
        end
        mst  = 0;
        mcmd = '0;
        mp   = 0;
    endtask

    task automatic model_edge(input bit [3:0] rb);
        bit [3:0] ev;
        int       nst;
        e++;
        for (int b = 0; b < 4; b++) begin
            hist[b].push_back(rb[b]);
            ev[b] = (evdue[b] == e);
        end
        for (int b = 0; b < 4; b++) begin
            bit old = deb[b];
            bit all = (e >= D);
            for (int k = e - D + 1; k <= e; k++)
                if (k < 1 || samp(b, k) == old) all = 1'b0;
            if (e >= 3 && !samp(b, e) && !old) armed[b] = 1'b1;
            if (all) begin
                deb[b] = !old;
                if (!old && armed[b]) evdue[b] = e + 2;
            end
        end
        nst  = mst;
        mcmd = '0;
        if (ev[3]) begin
            nst = 0; mcmd[3] = 1'b1;
        end else if (ev[2] && (mst == 1 || mst == 2)) begin
            nst = 3; mcmd[2] = 1'b1;
        end else if (ev[1] && mst == 1) begin
            nst = 2; mcmd[1] = 1'b1;
        end else if (ev[0]) begin
`ifdef TOGGLE_START_EN
            if (mst == 1 || mst == 2) begin nst = 3; mcmd[2] = 1'b1; end
            else                      begin nst = 1; mcmd[0] = 1'b1; end
`else
            if (mst != 1) begin nst = 1; mcmd[0] = 1'b1; end
`endif
        end
        if (nst == 0)                mp = 0;
        else if (mst == 1 || mst == 2) mp = (mp + 1) % C;
        mst = nst;
    endtask

    task automatic step(input bit [3:0] rb);
        bit tick_exp;
        {bz, bpr, bpa, bi} = rb;
        @(posedge clock);
        model_edge(rb);
        #1;
        tick_exp = (mst == 1 || mst == 2) && (mp == C - 1);
        check("estado", 32'(estado), 32'(mst));
        check("cmd", 32'({cmd_zerar, cmd_parar, cmd_pausar, cmd_contar}), 32'(mcmd));
        check("tick_seg", 32'(tick_seg), 32'(tick_exp));
    endtask

    task automatic apply_reset(input int cycles, input bit [3:0] hold);
        reset = 1'b0;
        #1;
        check("rst_async_estado", 32'(estado), 0);
        for (int i = 0; i < cycles; i++) begin
            {bz, bpr, bpa, bi} = 4'($urandom);
            @(posedge clock);
            #1;
            check("rst_outputs", 32'({estado, cmd_zerar, cmd_parar, cmd_pausar, cmd_contar, tick_seg}), 0);
        end
        {bz, bpr, bpa, bi} = hold;
        reset = 1'b1;
        model_reset();
    endtask

    initial begin
        int lat;
        model_reset();
        #2;
        apply_reset(6, 4'b0001);

        // Start held through reset release must not start the watch.
        for (int i = 0; i < 14; i++) step(4'b0001);
        check("held_thru_reset", 32'(estado), 0);
        for (int i = 0; i < 10; i++) step(4'b0000);

        // Start latency: first high sample edge N -> cmd_contar after edge N+3+D.
        lat = -1;
        for (int i = 1; i <= 12; i++) begin
            step(4'b0001);
            if (cmd_contar && lat < 0) lat = i;
        end
        check("start_latency", 32'(lat), 32'(D + 4));
        for (int i = 0; i < 25; i++) step(4'b0000);

        // Bounce on pausar, then a clean press.
        foreach (hist[0][i]) ;
        step(4'b0010); step(4'b0000); step(4'b0010); step(4'b0000); step(4'b0010);
        for (int i = 0; i < 8; i++) step(4'b0000);
        check("bounce_no_pause", 32'(estado), 1);
        for (int i = 0; i < 7; i++) step(4'b0010);
        for (int i = 0; i < 8; i++) step(4'b0000);
        check("pause_state", 32'(estado), 2);

        // Stop, resume, then simultaneous zerar+parar from CONTANDO.
        for (int i = 0; i < 7; i++) step(4'b0100);
        for (int i = 0; i < 8; i++) step(4'b0000);
        check("stop_state", 32'(estado), 3);
        for (int i = 0; i < 7; i++) step(4'b0001);
        for (int i = 0; i < 8; i++) step(4'b0000);
        check("resume_state", 32'(estado), 1);
        for (int i = 0; i < 7; i++) step(4'b0001);
        for (int i = 0; i < 8; i++) step(4'b0000);
`ifdef TOGGLE_START_EN
        check("toggle_state", 32'(estado), 3);
        for (int i = 0; i < 7; i++) step(4'b0001);
        for (int i = 0; i < 8; i++) step(4'b0000);
`else
        check("toggle_state", 32'(estado), 1);
`endif
        for (int i = 0; i < 7; i++) step(4'b1100);
        for (int i = 0; i < 8; i++) step(4'b0000);
        check("simul_zerar", 32'(estado), 0);

        // Random button traffic with glitches, one mid-run reset.
        for (int it = 0; it < 250; it++) begin
            bit [3:0] rb;
            int sel  = $urandom_range(0, 9);
            int hold = $urandom_range(1, 9);
            int gap  = $urandom_range(1, 12);
            if      (sel <= 3) rb = 4'b0001;
            else if (sel <= 5) rb = 4'b0010;
            else if (sel <= 7) rb = 4'b0100;
            else if (sel == 8) rb = 4'b1000;
            else               rb = 4'($urandom);
            if (it == 120) apply_reset(3, '0);
            for (int i = 0; i < hold; i++)
                step(($urandom_range(0, 99) < 15) ? 4'b0000 : rb);
            for (int i = 0; i < gap; i++) step(4'b0000);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
